// File: rtl/uart_tx_baud.sv
// UART transmitter with an internal baud-period counter.
// Frame: start, DATA_BITS data LSB-first, optional parity, STOP_BITS stop bits.
module uart_tx_baud #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST  = IDX_W'(STOP_BITS - 1);

  // Reject parameter sets the datapath is not sized for
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_baud: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_tx_baud: DATA_BITS must be in 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_baud: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 baud_tick;

  assign baud_tick = (cnt_q == CNT_LAST);
  assign tx_ready  = (state_q == S_IDLE);
  assign busy      = ~tx_ready;
  assign tx        = tx_q;

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state: tx_d is the line level for the bit that starts after this edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      idx_d = '0;
      tx_d  = 1'b1;
      if (tx_valid) begin
        shift_d = tx_data;
        par_d   = (PARITY_ODD != 0) ? ~(^tx_data) : (^tx_data);
        state_d = S_START;
        tx_d    = 1'b0;
      end
    end else if (!baud_tick) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
        S_DATA: begin
          if (idx_q == IDX_DATA_LAST) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
        S_STOP: begin
          tx_d = 1'b1;
          if (idx_q == IDX_STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

endmodule
